// File: rtl/seq_divider_32by16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_32by16_pkg
// Brief    : Shared constants and state encoding for the sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
package seq_divider_32by16_pkg;

    localparam int c_DEFAULT_WIDTH = 16;
    localparam int c_CNT_WIDTH     = $clog2(c_DEFAULT_WIDTH);

    localparam logic [1:0] c_STATE_IDLE = 2'd0;
    localparam logic [1:0] c_STATE_CALC = 2'd1;
    localparam logic [1:0] c_STATE_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/seq_divider_32by16_div_step.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_32by16_div_step
// Brief    : One restoring-division step: shift in a bit, trial-subtract.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider_32by16_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qBit
);

    logic [WIDTH:0] w_trial;
    logic           w_fits;

    assign w_trial = {i_rem, i_bit};
    assign w_fits  = (w_trial >= {1'b0, i_divisor});

    // Partial remainder is below the divisor, so the difference fits in WIDTH bits.
    assign o_rem  = w_fits ? (w_trial[WIDTH-1:0] - i_divisor) : w_trial[WIDTH-1:0];
    assign o_qBit = w_fits;

endmodule
`default_nettype wire

// File: rtl/seq_divider_32by16.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_32by16
// Brief    : Iterative restoring 2W/W divider, one quotient bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider_32by16
    import seq_divider_32by16_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_divByZero;
    logic               r_overflow;

    logic [WIDTH-1:0]   w_nextRem;
    logic               w_qBit;

    seq_divider_32by16_div_step #(
        .WIDTH (WIDTH)
    ) u_divStep (
        .i_rem     (r_rem),
        .i_bit     (r_quo[WIDTH-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_nextRem),
        .o_qBit    (w_qBit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_STATE_IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_divisor   <= '0;
            r_cnt       <= '0;
            r_divByZero <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                c_STATE_IDLE: begin
                    if (in_valid) begin
                        r_divisor   <= divisor;
                        r_cnt       <= '0;
                        r_divByZero <= 1'b0;
                        r_overflow  <= 1'b0;
                        if (divisor == '0) begin
                            r_divByZero <= 1'b1;
                            r_quo       <= '1;
                            r_rem       <= dividend[WIDTH-1:0];
                            r_state     <= c_STATE_DONE;
                        end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
                            // Quotient would need more than WIDTH bits.
                            r_overflow  <= 1'b1;
                            r_quo       <= '1;
                            r_rem       <= '0;
                            r_state     <= c_STATE_DONE;
                        end else begin
                            r_rem       <= dividend[2*WIDTH-1:WIDTH];
                            r_quo       <= dividend[WIDTH-1:0];
                            r_state     <= c_STATE_CALC;
                        end
                    end
                end
                c_STATE_CALC: begin
                    // Dividend low bits shift out of r_quo as quotient bits shift in.
                    r_rem <= w_nextRem;
                    r_quo <= {r_quo[WIDTH-2:0], w_qBit};
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_state <= c_STATE_DONE;
                    end
                end
                c_STATE_DONE: begin
                    if (out_ready) begin
                        r_state <= c_STATE_IDLE;
                    end
                end
                default: begin
                    r_state <= c_STATE_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == c_STATE_IDLE);
    assign out_valid   = (r_state == c_STATE_DONE);
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_divByZero;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire
